// File: rtl/sigcap_pkg.sv
// Shared definitions for the triggered sample-capture stage.
// Contents:
//   sigcap_state_t - control FSM state encoding
//   state_is_busy  - decode of the states in which a capture is in progress
package sigcap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_WAIT_TRIG  = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_DONE       = 3'd4
  } sigcap_state_t;

  // A capture is in progress from arming until the last sample is stored.
  function automatic logic state_is_busy(input sigcap_state_t s);
    logic b;
    case (s)
      ST_WAIT_FIRST: b = 1'b1;
      ST_WAIT_TRIG:  b = 1'b1;
      ST_CAPTURE:    b = 1'b1;
      default:       b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sigcap_trigger_if.sv
// Signal bundle between the sample source / readback client and sigcap_trigger.
// Signals:
//   en      - sample strobe, din valid when high
//   din     - unsigned sample
//   arm     - single-cycle capture request
//   level   - unsigned trigger threshold
//   rd_addr - readback address
//   rd_data - registered RAM word at rd_addr (one-cycle latency)
//   busy    - capture armed or in progress
//   done    - capture complete
// Modports: master drives stimulus and reads results, slave is the capture block.
interface sigcap_trigger_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic                     en;
  logic [DATA_WIDTH-1:0]    din;
  logic                     arm;
  logic [DATA_WIDTH-1:0]    level;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     busy;
  logic                     done;

  modport master (
    output en, din, arm, level, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  en, din, arm, level, rd_addr,
    output rd_data, busy, done
  );
endinterface

// File: rtl/sigcap_trigger_capture_ram.sv
// Simple dual-port capture RAM: one write port, one synchronous read port.
// Ports:
//   clk   - clock
//   rst   - async active-high reset, clears only the read register
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - registered read data; a same-address write in the same cycle
//           returns the previous contents
module capture_ram #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Storage array; deliberately not reset so captures survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; sampling mem before the write lands gives old-data behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/sigcap_trigger.sv
// Triggered sample capture. After arm, the first en sample primes the
// previous-sample register; a later en sample that rises through level
// (prev < level <= din) is stored at address 0, and the following samples
// fill the rest of the RAM. The snapshot is then frozen until the next trigger.
// Ports:
//   clk - clock
//   rst - async active-high reset
//   bus - sigcap_trigger_if slave (en, din, arm, level, rd_addr in;
//         rd_data, busy, done out)
module sigcap_trigger
  import sigcap_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  sigcap_trigger_if.slave    bus
);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ZERO = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = ADDRESS_WIDTH'(1'b1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_LAST = {ADDRESS_WIDTH{1'b1}};

  sigcap_state_t             state;
  sigcap_state_t             state_next;
  logic [DATA_WIDTH-1:0]     prev;
  logic [DATA_WIDTH-1:0]     prev_next;
  logic [ADDRESS_WIDTH-1:0]  wr_ptr;
  logic [ADDRESS_WIDTH-1:0]  wr_ptr_next;
  logic                      wr_en;
  logic [ADDRESS_WIDTH-1:0]  wr_addr;
  logic                      trig;
  logic                      busy;
  logic                      done;

  // Rising crossing; level is taken live so a change applies to the next sample.
  assign trig = (prev < bus.level) && (bus.din >= bus.level);

  // Next-state, prev/pointer update and RAM write decode.
  always_comb begin
    state_next  = state;
    prev_next   = prev;
    wr_ptr_next = wr_ptr;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr;
    case (state)
      ST_IDLE: begin
        if (bus.arm) begin
          state_next = ST_WAIT_FIRST;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_FIRST: begin
        // The first sample has no predecessor, so it only primes prev.
        if (bus.en) begin
          prev_next  = bus.din;
          state_next = ST_WAIT_TRIG;
        end else begin
          state_next = ST_WAIT_FIRST;
        end
      end
      ST_WAIT_TRIG: begin
        if (bus.en) begin
          if (trig) begin
            wr_en       = 1'b1;
            wr_addr     = PTR_ZERO;
            wr_ptr_next = PTR_ONE;
            // A one-word RAM is already full after the trigger sample.
            if (PTR_LAST == PTR_ZERO) begin
              state_next = ST_DONE;
            end else begin
              state_next = ST_CAPTURE;
            end
          end else begin
            prev_next = bus.din;
          end
        end else begin
          state_next = ST_WAIT_TRIG;
        end
      end
      ST_CAPTURE: begin
        if (bus.en) begin
          wr_en       = 1'b1;
          wr_addr     = wr_ptr;
          wr_ptr_next = wr_ptr + PTR_ONE;
          if (wr_ptr == PTR_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CAPTURE;
          end
        end else begin
          state_next = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (bus.arm) begin
          state_next = ST_WAIT_FIRST;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control state; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      prev   <= {DATA_WIDTH{1'b0}};
      wr_ptr <= PTR_ZERO;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      prev   <= prev_next;
      wr_ptr <= wr_ptr_next;
      busy   <= state_is_busy(state_next);
      done   <= (state_next == ST_DONE);
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;

  capture_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (bus.din),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );
endmodule
